// File: rtl/dexu_pkg.sv
// Shared definitions for the RV32I decode/execute slice.
// Contents: opcode constants, the ALU operation enum, one-hot memory length
// codes, the halt word, and a helper that maps funct3 onto an ALU operation.
package dexu_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  localparam logic [2:0] MEM_LEN_NONE = 3'b000;
  localparam logic [2:0] MEM_LEN_BYTE = 3'b001;
  localparam logic [2:0] MEM_LEN_HALF = 3'b010;
  localparam logic [2:0] MEM_LEN_WORD = 3'b100;

  localparam logic [31:0] HALT_WORD   = 32'h0000007f;
  localparam logic [31:0] ECALL_WORD  = 32'h00000073;
  localparam logic [31:0] EBREAK_WORD = 32'h00100073;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_ZERO
  } alu_op_e;

  // alt selects SUB for funct3=000 and SRA for funct3=101; ignored otherwise.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/data_mux.sv
// 2:1 word select used for ALU operand steering.
// Ports: sel (1 = in1), in0/in1 (32-bit data), out (selected word).
module data_mux (
  input  logic        sel,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic [31:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/decode_exec_unit.sv
// RV32I decode, operand select and ALU for the single-cycle core.
// Everything from inst to alu_out/alu_jmp is combinational; the only state is
// the sticky illegal_seen flag and, when DEXU_INST_COUNT_EN is defined, a
// retired-instruction counter exposed on inst_count.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   inst, pc_cur             instruction word and its pc
//   rdata1, rdata2           register file read data for rs1/rs2
//   rs1, rs2, rd             register addresses
//   write_reg, write_reg_mux regfile write enable / source (1 = memory)
//   write_mem, mem_wea       store strobe and byte enables
//   mem_len, mem_signed_ext  access size (one-hot) and load sign extension
//   pc_reg_src, pc_imm       jump base select (1 = rdata1) and offset
//   alu_out, alu_jmp         ALU result / data address, take-jump flag
//   illegal, illegal_seen    unsupported inst now / ever since reset
//   inst_count               retired count (only with DEXU_INST_COUNT_EN)
module decode_exec_unit
  import dexu_pkg::*;
#(
  parameter int          XLEN   = 32,
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic [31:0]     pc_cur,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            write_reg,
  output logic            write_reg_mux,
  output logic            write_mem,
  output logic [3:0]      mem_wea,
  output logic [2:0]      mem_len,
  output logic            mem_signed_ext,
  output logic            pc_reg_src,
  output logic [31:0]     pc_imm,
  output logic [XLEN-1:0] alu_out,
  output logic            alu_jmp,
  output logic            illegal,
`ifdef DEXU_INST_COUNT_EN
  output logic [31:0]     inst_count,
`endif
  output logic            illegal_seen
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic        legal;
  logic        is_wb, is_load, is_store, is_branch, is_jal, is_jalr;
  logic        a_sel_pc, a_sel_zero, b_sel_rs2, b_sel_inc;
  logic [31:0] imm_op;
  logic [31:0] pc_imm_d;
  alu_op_e     alu_op;

  logic [31:0] zero_word;
  logic [31:0] op_a_pc, op_a, op_b_imm, op_b;
  logic [31:0] alu_res;
  logic        br_taken;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    legal      = 1'b1;
    is_wb      = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jal     = 1'b0;
    is_jalr    = 1'b0;
    a_sel_pc   = 1'b0;
    a_sel_zero = 1'b0;
    b_sel_rs2  = 1'b0;
    b_sel_inc  = 1'b0;
    imm_op     = imm_i;
    pc_imm_d   = 32'h0;
    alu_op     = ALU_ZERO;

    case (opcode)
      OP: begin
        legal     = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        is_wb     = 1'b1;
        b_sel_rs2 = 1'b1;
        alu_op    = alu_op_from_f3(f3, f7[5]);
      end
      OP_IMM: begin
        // Only the shift forms carry a funct7 field; the rest use the full imm.
        if (f3 == 3'b001)
          legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        is_wb  = 1'b1;
        imm_op = imm_i;
        alu_op = alu_op_from_f3(f3, (f3 == 3'b101) && inst[30]);
      end
      LOAD: begin
        legal   = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        is_load = 1'b1;
        is_wb   = 1'b1;
        imm_op  = imm_i;
        alu_op  = ALU_ADD;
      end
      STORE: begin
        legal    = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        is_store = 1'b1;
        imm_op   = imm_s;
        alu_op   = ALU_ADD;
      end
      BRANCH: begin
        legal     = (f3 != 3'b010) && (f3 != 3'b011);
        is_branch = 1'b1;
        b_sel_rs2 = 1'b1;
        pc_imm_d  = imm_b;
        alu_op    = ALU_ZERO;
      end
      JAL: begin
        is_jal    = 1'b1;
        is_wb     = 1'b1;
        a_sel_pc  = 1'b1;
        b_sel_inc = 1'b1;
        pc_imm_d  = imm_j;
        alu_op    = ALU_ADD;
      end
      JALR: begin
        legal     = (f3 == 3'b000);
        is_jalr   = 1'b1;
        is_wb     = 1'b1;
        a_sel_pc  = 1'b1;
        b_sel_inc = 1'b1;
        pc_imm_d  = imm_i;
        alu_op    = ALU_ADD;
      end
      LUI: begin
        is_wb      = 1'b1;
        a_sel_zero = 1'b1;
        imm_op     = imm_u;
        alu_op     = ALU_ADD;
      end
      AUIPC: begin
        is_wb    = 1'b1;
        a_sel_pc = 1'b1;
        imm_op   = imm_u;
        alu_op   = ALU_ADD;
      end
      MISC_MEM: begin
        legal = (f3 == 3'b000);
      end
      SYSTEM: begin
        // Only ECALL/EBREAK decode as legal; CSR forms are flagged illegal.
        legal = (inst == ECALL_WORD) || (inst == EBREAK_WORD);
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    if (inst == HALT_WORD)
      legal = 1'b0;
  end

  assign zero_word = 32'h0;

  // Operand A: rdata1, then pc, then forced zero for LUI.
  data_mux u_mux_a_pc (
    .sel (a_sel_pc),
    .in0 (rdata1),
    .in1 (pc_cur),
    .out (op_a_pc)
  );

  data_mux u_mux_a_zero (
    .sel (a_sel_zero),
    .in0 (op_a_pc),
    .in1 (zero_word),
    .out (op_a)
  );

  // Operand B: immediate or link increment, then rdata2 for register forms.
  data_mux u_mux_b_inc (
    .sel (b_sel_inc),
    .in0 (imm_op),
    .in1 (PC_INC),
    .out (op_b_imm)
  );

  data_mux u_mux_b_rs2 (
    .sel (b_sel_rs2),
    .in0 (op_b_imm),
    .in1 (rdata2),
    .out (op_b)
  );

  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'b0, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = 32'h0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (op_a == op_b);
      3'b001:  br_taken = (op_a != op_b);
      3'b100:  br_taken = $signed(op_a) <  $signed(op_b);
      3'b101:  br_taken = $signed(op_a) >= $signed(op_b);
      3'b110:  br_taken = op_a <  op_b;
      3'b111:  br_taken = op_a >= op_b;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_wea = 4'b0000;
    mem_len = MEM_LEN_NONE;
    if (legal && is_store) begin
      case (f3)
        3'b000:  mem_wea = 4'b0001;
        3'b001:  mem_wea = 4'b0011;
        3'b010:  mem_wea = 4'b1111;
        default: mem_wea = 4'b0000;
      endcase
    end
    if (legal && (is_load || is_store)) begin
      case (f3[1:0])
        2'b00:   mem_len = MEM_LEN_BYTE;
        2'b01:   mem_len = MEM_LEN_HALF;
        2'b10:   mem_len = MEM_LEN_WORD;
        default: mem_len = MEM_LEN_NONE;
      endcase
    end
  end

  assign illegal        = ~legal;
  assign write_reg      = legal & is_wb & (rd != 5'd0);
  assign write_reg_mux  = legal & is_load;
  assign write_mem      = legal & is_store;
  assign mem_signed_ext = legal & is_load & ((f3 == 3'b000) || (f3 == 3'b001));
  assign pc_reg_src     = legal & is_jalr;
  assign pc_imm         = pc_imm_d;
  assign alu_out        = legal ? alu_res : 32'h0;
  assign alu_jmp        = legal & (is_jal | is_jalr | (is_branch & br_taken));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_seen <= 1'b0;
    else if (illegal)
      illegal_seen <= 1'b1;
  end

`ifdef DEXU_INST_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inst_count <= 32'h0;
    else if (!illegal)
      inst_count <= inst_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_decode_exec_unit.sv
module tb_decode_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst, pc_cur, rdata1, rdata2;
  logic [4:0]  rs1, rs2, rd;
  logic        write_reg, write_reg_mux, write_mem;
  logic [3:0]  mem_wea;
  logic [2:0]  mem_len;
  logic        mem_signed_ext, pc_reg_src;
  logic [31:0] pc_imm, alu_out;
  logic        alu_jmp, illegal, illegal_seen;
`ifdef DEXU_INST_COUNT_EN
  logic [31:0] inst_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  decode_exec_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst           (inst),
    .pc_cur         (pc_cur),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .write_reg      (write_reg),
    .write_reg_mux  (write_reg_mux),
    .write_mem      (write_mem),
    .mem_wea        (mem_wea),
    .mem_len        (mem_len),
    .mem_signed_ext (mem_signed_ext),
    .pc_reg_src     (pc_reg_src),
    .pc_imm         (pc_imm),
    .alu_out        (alu_out),
    .alu_jmp        (alu_jmp),
    .illegal        (illegal),
`ifdef DEXU_INST_COUNT_EN
    .inst_count     (inst_count),
`endif
    .illegal_seen   (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    inst = i; pc_cur = p; rdata1 = r1; rdata2 = r2;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (illegal_seen !== 1'b0) begin n_bad++; $display("FAIL reset_seen got %b want 0", illegal_seen); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_alu;
    // ADD x3,x1,x2
    drive(32'h002081B3, 32'h0, 32'd5, 32'hFFFFFFFE);
    n_cmp++; if (alu_out !== 32'h3) begin n_bad++; $display("FAIL add_out got %h want 00000003", alu_out); end
    n_cmp++; if (write_reg !== 1'b1) begin n_bad++; $display("FAIL add_wr got %b want 1", write_reg); end
    n_cmp++; if (rd !== 5'd3 || rs1 !== 5'd1 || rs2 !== 5'd2) begin n_bad++; $display("FAIL add_regs got %0d/%0d/%0d want 3/1/2", rd, rs1, rs2); end
    n_cmp++; if (alu_jmp !== 1'b0) begin n_bad++; $display("FAIL add_jmp got %b want 0", alu_jmp); end
    // SUB x3,x1,x2
    drive(32'h402081B3, 32'h0, 32'd5, 32'hFFFFFFFE);
    n_cmp++; if (alu_out !== 32'h7) begin n_bad++; $display("FAIL sub_out got %h want 00000007", alu_out); end
    // ADD x0,x1,x2: rd=0 suppresses write
    drive(32'h00208033, 32'h0, 32'd5, 32'd6);
    n_cmp++; if (write_reg !== 1'b0) begin n_bad++; $display("FAIL x0_wr got %b want 0", write_reg); end
    // LUI x7,0x12345 and AUIPC x7,0x12345
    drive(32'h123453B7, 32'h100, 32'hDEADBEEF, 32'h0);
    n_cmp++; if (alu_out !== 32'h12345000) begin n_bad++; $display("FAIL lui_out got %h want 12345000", alu_out); end
    drive(32'h12345397, 32'h100, 32'hDEADBEEF, 32'h0);
    n_cmp++; if (alu_out !== 32'h12345100) begin n_bad++; $display("FAIL auipc_out got %h want 12345100", alu_out); end
  endtask

  task automatic test_shift;
    drive(32'h40435293, 32'h0, 32'h80000000, 32'h0);
    n_cmp++; if (alu_out !== 32'hF8000000) begin n_bad++; $display("FAIL srai_out got %h want f8000000", alu_out); end
    drive(32'h00435293, 32'h0, 32'h80000000, 32'h0);
    n_cmp++; if (alu_out !== 32'h08000000) begin n_bad++; $display("FAIL srli_out got %h want 08000000", alu_out); end
  endtask

  task automatic test_branch;
    drive(32'hFE20ECE3, 32'h200, 32'd1, 32'hFFFFFFFF);
    n_cmp++; if (alu_jmp !== 1'b1) begin n_bad++; $display("FAIL bltu_jmp got %b want 1", alu_jmp); end
    n_cmp++; if (pc_imm !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL bltu_imm got %h want fffffff8", pc_imm); end
    n_cmp++; if (alu_out !== 32'h0 || write_reg !== 1'b0) begin n_bad++; $display("FAIL bltu_out got %h/%b want 0/0", alu_out, write_reg); end
    drive(32'hFE20CCE3, 32'h200, 32'd1, 32'hFFFFFFFF);
    n_cmp++; if (alu_jmp !== 1'b0) begin n_bad++; $display("FAIL blt_jmp got %b want 0", alu_jmp); end
  endtask

  task automatic test_jump;
    drive(32'h00C380E7, 32'h100, 32'h4000, 32'h0);
    n_cmp++; if (alu_out !== 32'h104) begin n_bad++; $display("FAIL jalr_out got %h want 00000104", alu_out); end
    n_cmp++; if (pc_reg_src !== 1'b1) begin n_bad++; $display("FAIL jalr_src got %b want 1", pc_reg_src); end
    n_cmp++; if (pc_imm !== 32'd12) begin n_bad++; $display("FAIL jalr_imm got %h want 0000000c", pc_imm); end
    n_cmp++; if (alu_jmp !== 1'b1 || write_reg !== 1'b1) begin n_bad++; $display("FAIL jalr_ctl got %b/%b want 1/1", alu_jmp, write_reg); end
    drive(32'h010000EF, 32'h300, 32'h0, 32'h0);
    n_cmp++; if (pc_imm !== 32'd16 || alu_out !== 32'h304) begin n_bad++; $display("FAIL jal got imm %h out %h want 00000010 00000304", pc_imm, alu_out); end
    n_cmp++; if (pc_reg_src !== 1'b0 || alu_jmp !== 1'b1) begin n_bad++; $display("FAIL jal_ctl got %b/%b want 0/1", pc_reg_src, alu_jmp); end
  endtask

  task automatic test_mem;
    // SH x2,-2(x1)
    drive(32'hFE209F23, 32'h0, 32'h1000, 32'h55);
    n_cmp++; if (write_mem !== 1'b1 || write_reg !== 1'b0) begin n_bad++; $display("FAIL sh_wr got %b/%b want 1/0", write_mem, write_reg); end
    n_cmp++; if (mem_wea !== 4'b0011) begin n_bad++; $display("FAIL sh_wea got %b want 0011", mem_wea); end
    n_cmp++; if (mem_len !== 3'b010) begin n_bad++; $display("FAIL sh_len got %b want 010", mem_len); end
    n_cmp++; if (alu_out !== 32'h00000FFE) begin n_bad++; $display("FAIL sh_addr got %h want 00000ffe", alu_out); end
    // SW x2,0(x1)
    drive(32'h0020A023, 32'h0, 32'h1000, 32'h55);
    n_cmp++; if (mem_wea !== 4'b1111 || mem_len !== 3'b100) begin n_bad++; $display("FAIL sw got %b/%b want 1111/100", mem_wea, mem_len); end
    // LB x4,3(x1)
    drive(32'h00308203, 32'h0, 32'h1000, 32'h0);
    n_cmp++; if (write_reg_mux !== 1'b1 || mem_signed_ext !== 1'b1) begin n_bad++; $display("FAIL lb_ctl got %b/%b want 1/1", write_reg_mux, mem_signed_ext); end
    n_cmp++; if (mem_len !== 3'b001 || mem_wea !== 4'b0000 || write_mem !== 1'b0) begin n_bad++; $display("FAIL lb_mem got %b/%b/%b want 001/0000/0", mem_len, mem_wea, write_mem); end
    n_cmp++; if (alu_out !== 32'h1003 || write_reg !== 1'b1) begin n_bad++; $display("FAIL lb_out got %h/%b want 00001003/1", alu_out, write_reg); end
  endtask

  task automatic test_illegal_sticky;
    drive(32'h00000073, 32'h0, 32'h1, 32'h1);
    n_cmp++; if (illegal !== 1'b0 || write_reg !== 1'b0 || alu_jmp !== 1'b0) begin n_bad++; $display("FAIL ecall got %b/%b/%b want 0/0/0", illegal, write_reg, alu_jmp); end
    @(posedge clk); #1;
    n_cmp++; if (illegal_seen !== 1'b0) begin n_bad++; $display("FAIL seen_legal got %b want 0", illegal_seen); end
    drive(32'h0000007F, 32'h0, 32'h1, 32'h1);
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL halt_ill got %b want 1", illegal); end
    n_cmp++; if (write_reg !== 1'b0 || write_mem !== 1'b0 || mem_wea !== 4'b0 || alu_jmp !== 1'b0 || alu_out !== 32'h0) begin n_bad++; $display("FAIL halt_ctl got %b/%b/%b/%b/%h want all 0", write_reg, write_mem, mem_wea, alu_jmp, alu_out); end
    n_cmp++; if (illegal_seen !== 1'b0) begin n_bad++; $display("FAIL seen_pre got %b want 0", illegal_seen); end
    @(posedge clk); #1;
    n_cmp++; if (illegal_seen !== 1'b1) begin n_bad++; $display("FAIL seen_set got %b want 1", illegal_seen); end
    drive(32'h002081B3, 32'h0, 32'h1, 32'h1);
    @(posedge clk); #1;
    n_cmp++; if (illegal_seen !== 1'b1) begin n_bad++; $display("FAIL seen_sticky got %b want 1", illegal_seen); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (illegal_seen !== 1'b0) begin n_bad++; $display("FAIL seen_rst got %b want 0", illegal_seen); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_illegal_funct;
    // OP with funct7=0000001 (M extension) is unsupported
    drive(32'h022081B3, 32'h0, 32'd5, 32'd6);
    n_cmp++; if (illegal !== 1'b1 || write_reg !== 1'b0 || alu_out !== 32'h0) begin n_bad++; $display("FAIL mul_ill got %b/%b/%h want 1/0/0", illegal, write_reg, alu_out); end
    // SRAI with funct7=0100001
    drive(32'h42435293, 32'h0, 32'h80000000, 32'h0);
    n_cmp++; if (illegal !== 1'b1 || write_reg !== 1'b0) begin n_bad++; $display("FAIL srai_f7 got %b/%b want 1/0", illegal, write_reg); end
  endtask

  initial begin
    inst = 32'h00000013; pc_cur = 32'h0; rdata1 = 32'h0; rdata2 = 32'h0;
    test_reset;
    test_alu;
    test_shift;
    test_branch;
    test_jump;
    test_mem;
    test_illegal_sticky;
    test_illegal_funct;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
